// File: rtl/perm_reorder_buffer.sv
// Permutation-checked frame reorder buffer: validates a latched permutation,
// buffers N input words and replays them as out[k] = in[perm[k]].
module perm_reorder_buffer #(
    parameter int N      = 100,
    parameter int W      = $clog2(N),
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N*W-1:0]    perm_in,
    input  logic              perm_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done,
    output logic              perm_err
);

    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W:0]   NUM  = (W + 1)'(N);

    typedef enum logic [1:0] {IDLE, CHECK, FILL, DRAIN} state_t;

    state_t            state, state_next;
    logic [N*W-1:0]    perm_reg;
    logic [N-1:0]      seen;
    logic [W-1:0]      k, wr, rd;
    logic [DATA_W-1:0] mem [N];

    logic [W-1:0] v, pidx;
    logic         chk_bad, in_hs, load, final_hs;

    always_comb begin
        v        = perm_reg[int'(k) * W +: W];
        pidx     = perm_reg[int'(rd) * W +: W];
        chk_bad  = ({1'b0, v} >= NUM) ? 1'b1 : seen[v];
        in_hs    = (state == FILL) && in_valid;
        final_hs = (state == DRAIN) && out_valid && out_ready && out_last;
        // the last word stays in the output register until it is taken; no reload behind it
        load     = (state == DRAIN) && (!out_valid || out_ready) && !(out_valid && out_last);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (perm_valid) state_next = CHECK;
            CHECK: begin
                if (chk_bad)        state_next = IDLE;
                else if (k == LAST) state_next = FILL;
            end
            FILL:  if (in_hs && wr == LAST) state_next = DRAIN;
            DRAIN: if (final_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready = (state == FILL);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            k          <= '0;
            wr         <= '0;
            rd         <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            perm_err   <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    k  <= '0;
                    wr <= '0;
                    rd <= '0;
                end
                CHECK: begin
                    if (chk_bad) perm_err <= 1'b1;
                    else         k <= k + 1'b1;
                end
                FILL: if (in_hs) wr <= wr + 1'b1;
                DRAIN: begin
                    if (load) begin
                        out_data  <= mem[pidx];
                        out_last  <= (rd == LAST);
                        out_valid <= 1'b1;
                        rd        <= rd + 1'b1;
                    end else if (final_hs) begin
                        out_valid  <= 1'b0;
                        out_last   <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == IDLE && perm_valid) begin
                perm_reg <= perm_in;
                seen     <= '0;
            end
            if (state == CHECK && !chk_bad) seen[v] <= 1'b1;
            if (in_hs) mem[wr] <= in_data;
        end
    end

endmodule

// File: tb/tb_perm_reorder_buffer.sv
// Randomized self-checking bench for perm_reorder_buffer (N=4 main instance, N=5 range-check instance).
module tb_perm_reorder_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] perm_in;
    logic       perm_valid;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_ready, out_last, busy, frame_done, perm_err;

    logic [14:0] perm_in5;
    logic        perm_valid5;
    logic [7:0]  in_data5;
    logic        in_valid5, in_ready5;
    logic [7:0]  out_data5;
    logic        out_valid5, out_ready5, out_last5, busy5, frame_done5, perm_err5;

    perm_reorder_buffer #(.N(4), .W(2), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .perm_in(perm_in), .perm_valid(perm_valid),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .frame_done(frame_done), .perm_err(perm_err)
    );

    perm_reorder_buffer #(.N(5), .W(3), .DATA_W(8)) dut5 (
        .clk(clk), .reset(reset), .perm_in(perm_in5), .perm_valid(perm_valid5),
        .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5),
        .out_last(out_last5), .busy(busy5), .frame_done(frame_done5), .perm_err(perm_err5)
    );

    int         checks = 0;
    int         errors = 0;
    bit         err_exp = 1'b0;
    int         pa [4];
    logic [7:0] da [4];
    int         p5 [5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference: index of the first entry that is out of range or repeats an earlier one
    function automatic int first_bad();
        bit seen [4];
        for (int i = 0; i < 4; i++) seen[i] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pa[i] >= 4 || seen[pa[i]]) return i;
            seen[pa[i]] = 1'b1;
        end
        return -1;
    endfunction

    task automatic pack_perm();
        for (int i = 0; i < 4; i++) perm_in[i*2 +: 2] = 2'(pa[i]);
    endtask

    // Starts from a sample point with the block in IDLE; ends on the frame_done sample.
    task automatic do_frame(input int mode, input bit hold_pv, input int abort_at);
        int lat, idx, dc, gap;
        bit done;
        pack_perm();
        perm_valid = 1'b1;
        out_ready  = 1'b0;
        in_valid   = 1'b0;
        step();
        if (!hold_pv) perm_valid = 1'b0;
        perm_in = 8'($urandom);
        lat = 1;
        while (!in_ready && lat < 20) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            step();
            lat++;
        end
        chk("in_ready_latency", lat, 5);
        for (int i = 0; i < 4; i++) begin
            gap = 0;
            while ($urandom_range(0, 2) == 0 && gap < 4) begin
                in_valid = 1'b0;
                step();
                gap++;
            end
            chk("fill_ready", in_ready, 1);
            in_valid = 1'b1;
            in_data  = da[i];
            step();
        end
        in_data = 8'($urandom);
        chk("ready_drop", in_ready, 0);
        chk("ov_before", out_valid, 0);
        step();
        idx = 0;
        dc = 0;
        done = 1'b0;
        while (!done && dc < 40) begin
            if (idx == 4) begin
                chk("frame_done", frame_done, 1);
                chk("ov_after", out_valid, 0);
                chk("busy_after", busy, 0);
                done = 1'b1;
            end else if (idx == abort_at) begin
                reset      = 1'b1;
                perm_valid = 1'b0;
                in_valid   = 1'b0;
                step();
                chk("abort_ov", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_fd", frame_done, 0);
                chk("abort_err", perm_err, 0);
                reset = 1'b0;
                step();
                chk("abort_fd2", frame_done, 0);
                err_exp = 1'b0;
                out_ready = 1'b0;
                return;
            end else begin
                chk("out_valid", out_valid, 1);
                chk("frame_done_early", frame_done, 0);
                chk("out_data", out_data, da[pa[idx]]);
                chk("out_last", out_last, (idx == 3) ? 1 : 0);
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (dc % 3 == 0);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                if (out_ready) idx++;
                step();
                dc++;
            end
        end
        chk("drain_words", idx, 4);
        if (mode == 0) chk("throughput", dc, 4);
        chk("perm_err", perm_err, err_exp);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic do_bad();
        int e;
        e = first_bad();
        pack_perm();
        perm_valid = 1'b1;
        step();
        perm_valid = 1'b0;
        perm_in = 8'($urandom);
        for (int c = 1; c <= e + 1; c++) begin
            if (!err_exp) chk("err_pre", perm_err, 0);
            chk("busy_check", busy, 1);
            step();
        end
        chk("err_set", perm_err, 1);
        chk("err_idle", busy, 0);
        err_exp = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            step();
            chk("err_no_ready", in_ready, 0);
            chk("err_stay_idle", busy, 0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int lat, idx, dc, j, t;
        reset = 1'b1;
        perm_in = '0; perm_valid = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        perm_in5 = '0; perm_valid5 = 1'b0; in_data5 = '0; in_valid5 = 1'b0; out_ready5 = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_perm_err", perm_err, 0);

        // basic frame, then the same with a stalling consumer
        pa = '{2, 0, 1, 3};
        da = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        do_frame(0, 1'b0, -1);
        do_frame(1, 1'b0, -1);

        pa = '{0, 1, 1, 3};
        do_bad();

        // perm_valid held across two back-to-back frames
        pa = '{3, 2, 1, 0};
        da = '{8'd0, 8'd1, 8'd2, 8'd3};
        do_frame(0, 1'b1, -1);
        pa = '{1, 3, 0, 2};
        da = '{8'd4, 8'd5, 8'd6, 8'd7};
        do_frame(0, 1'b0, -1);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 4; i++) pa[i] = i;
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = pa[i]; pa[i] = pa[j]; pa[j] = t;
            end
            if ($urandom_range(0, 3) == 0) begin
                j = $urandom_range(1, 3);
                pa[j] = pa[j-1];
            end
            for (int i = 0; i < 4; i++) da[i] = 8'($urandom);
            if (first_bad() >= 0) do_bad();
            else                  do_frame(2, 1'b0, -1);
        end

        // reset after two of four outputs, then a clean frame
        pa = '{2, 0, 1, 3};
        da = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        do_frame(0, 1'b0, 2);
        do_frame(0, 1'b0, -1);

        // N=5: out-of-range entry 6, then a valid frame with perm_err kept
        p5 = '{0, 1, 6, 3, 4};
        for (int i = 0; i < 5; i++) perm_in5[i*3 +: 3] = 3'(p5[i]);
        perm_valid5 = 1'b1;
        step();
        perm_valid5 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("n5_err_pre", perm_err5, 0);
            step();
        end
        chk("n5_err_set", perm_err5, 1);
        chk("n5_idle", busy5, 0);

        p5 = '{4, 2, 0, 1, 3};
        for (int i = 0; i < 5; i++) perm_in5[i*3 +: 3] = 3'(p5[i]);
        perm_valid5 = 1'b1;
        step();
        perm_valid5 = 1'b0;
        lat = 1;
        while (!in_ready5 && lat < 20) begin
            step();
            lat++;
        end
        chk("n5_latency", lat, 6);
        for (int i = 0; i < 5; i++) begin
            in_valid5 = 1'b1;
            in_data5  = 8'(16 + i);
            step();
        end
        in_valid5  = 1'b0;
        out_ready5 = 1'b1;
        idx = 0;
        dc = 0;
        while (idx < 5 && dc < 20) begin
            if (out_valid5) begin
                chk("n5_data", out_data5, 16 + p5[idx]);
                chk("n5_last", out_last5, (idx == 4) ? 1 : 0);
                idx++;
            end
            step();
            dc++;
        end
        chk("n5_words", idx, 5);
        chk("n5_frame_done", frame_done5, 1);
        chk("n5_err_sticky", perm_err5, 1);
        out_ready5 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/perm_reorder_buffer.md
Name: perm_reorder_buffer

Overview:
- Downstream consumer of the random permutation generator.
- Latches the packed permutation vector and checks it sequentially for range and duplicate errors.
- Buffers one frame of N data words from an input stream.
- Replays the frame in permuted order on a valid/ready output stream: output word k = input word perm[k].

Parameters:
- N, 100, frame length and permutation size (N >= 2).
- W, $clog2(N), index width; entry i of perm_in is perm_in[i*W +: W].
- DATA_W, 8, data word width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- perm_in  input  N*W  packed permutation from the upstream generator.
- perm_valid  input  1  level; high while perm_in is valid (upstream done).
- in_data  input  DATA_W  input stream word.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts input word.
- out_data  output  DATA_W  reordered word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_last  output  1  marks word N-1 of the frame.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse after the final output handshake.
- perm_err  output  1  sticky; set on an invalid permutation.

Behaviour:
- Reset (synchronous): state=IDLE; counters=0; in_ready=0; out_valid=0; out_last=0; out_data=0; busy=0; frame_done=0; perm_err=0. Buffer and permutation register contents are not cleared. Reset mid-frame aborts the frame; no frame_done is issued.
- Handshakes: a transfer occurs on a cycle where valid and ready are both high at the clk edge.
- IDLE:
  - If perm_valid=1, latch perm_in into perm_reg, clear the seen[N] bitmap, set k=0, and go to CHECK.
  - If perm_valid is still high on return to IDLE, a new frame starts immediately with a re-latched vector.
- CHECK: one entry per cycle, k=0..N-1.
  - Error when v=perm_reg[k] satisfies v>=N or seen[v]=1: set perm_err=1 and go to IDLE.
  - Otherwise set seen[v]=1.
  - After k=N-1 passes, go to FILL.
  - CHECK therefore takes exactly N cycles for a valid vector.
- FILL:
  - in_ready=1.
  - Each input handshake writes buf[wr]=in_data, then wr++.
  - The handshake with wr=N-1 moves the block to DRAIN; in_ready=0 from the next cycle.
- DRAIN: the output register loads when out_valid=0, or when out_valid=1 and out_ready=1.
  - Load values: out_data=buf[perm_reg[rd]], out_last=(rd==N-1), out_valid=1, then rd++.
  - The first load happens in the first DRAIN cycle, so out_valid rises 2 cycles after the last input handshake.
  - Full throughput: 1 word per cycle while out_ready=1.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - On the handshake of the out_last word: out_valid=0, frame_done=1 for one cycle, state=IDLE, counters cleared.
- perm_err:
  - Stays set until reset.
  - Later frames are still attempted; a valid vector proceeds normally, and perm_err remains 1.
- Timing: perm_valid seen in IDLE at cycle t gives in_ready=1 first at cycle t+N+1.
- in_valid is ignored outside FILL.
- perm_in changes after latching have no effect on the current frame.

Test Plan:
- N=4, perm_in={3,1,0,2} (entry0=2, entry1=0, entry2=1, entry3=3); inputs A0,B1,C2,D3 with out_ready=1 -> outputs C2,A0,B1,D3; out_last on D3; frame_done one cycle later; perm_err=0.
- Same frame with out_ready toggling 1,0,0,1... -> out_data held during stalls; order and out_last unchanged; no word lost or duplicated.
- N=4, perm entries {0,1,1,3} -> perm_err=1 after the CHECK of k=2; in_ready never asserts; block returns to IDLE.
- N=5 (W=3), entry value 6 -> perm_err=1 on that entry; a subsequent valid vector completes a frame with perm_err still 1.
- perm_valid held high across two frames with inputs 0..3 then 4..7 -> both frames reordered correctly; CHECK repeats (N cycles) between frames.
- reset asserted after 2 of 4 outputs -> next cycle out_valid=0, busy=0, no frame_done; new frame after reset behaves as in scenario 1.
